// File: rtl/ctrl_pipe_chain.sv
// ctrl_pipe_chain: N-stage control-bundle pipeline (EX, MEM, WB, ...) with
// per-stage valid/rd/rd_wr/is_load, keep masks, load-use hazard bubbles,
// branch flush and external freeze. Drives the PC and IF/ID load enables.
// Optional build macro: CTRL_PIPE_STATS_EN adds saturating bubble, flush and
// freeze event counters.

// One pipeline stage register; MASK clears bundle bits not carried here.
module ctrl_pipe_stage #(
  parameter int                CTRL_W = 16,
  parameter int                REG_W  = 4,
  parameter logic [CTRL_W-1:0] MASK   = '1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic              d_vld,
  input  logic [REG_W-1:0]  d_rd,
  input  logic              d_rdwr,
  input  logic              d_ld,
  output logic [CTRL_W-1:0] q_ctrl,
  output logic              q_vld,
  output logic [REG_W-1:0]  q_rd,
  output logic              q_rdwr,
  output logic              q_ld
);
  // Capture the upstream stage when the chain advances
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_ctrl <= '0;
      q_vld  <= 1'b0;
      q_rd   <= '0;
      q_rdwr <= 1'b0;
      q_ld   <= 1'b0;
    end else if (en) begin
      q_ctrl <= d_ctrl & MASK;
      q_vld  <= d_vld;
      q_rd   <= d_rd;
      q_rdwr <= d_rdwr;
      q_ld   <= d_ld;
    end
  end
endmodule

module ctrl_pipe_chain #(
  parameter int                         CTRL_W    = 16,
  parameter int                         N_STAGES  = 3,
  parameter int                         REG_W     = 4,
  parameter int                         LOAD_LAT  = 1,
  parameter logic [N_STAGES*CTRL_W-1:0] KEEP_MASK = '1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [CTRL_W-1:0]            id_ctrl,
  input  logic                         id_valid,
  input  logic [REG_W-1:0]             id_rs1,
  input  logic [REG_W-1:0]             id_rs2,
  input  logic                         id_use_rs1,
  input  logic                         id_use_rs2,
  input  logic [REG_W-1:0]             id_rd,
  input  logic                         id_rd_wr,
  input  logic                         id_is_load,
  input  logic                         flush,
  input  logic                         stall_ext,
  output logic [N_STAGES*CTRL_W-1:0]   stage_ctrl,
  output logic [N_STAGES-1:0]          stage_valid,
  output logic [N_STAGES*REG_W-1:0]    stage_rd,
  output logic [N_STAGES-1:0]          stage_rd_wr,
  output logic                         pc_le,
  output logic                         ifid_le,
`ifdef CTRL_PIPE_STATS_EN
  output logic [15:0]                  bubble_cnt,
  output logic [15:0]                  flush_cnt,
  output logic [15:0]                  freeze_cnt,
`endif
  output logic                         hazard_stall
);
  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] STALL = 1'b1;
  localparam int         CW    = $clog2(LOAD_LAT + 1);

  // Index 0 is the stage-0 input; index k+1 is the output of stage k.
  logic [N_STAGES:0][CTRL_W-1:0] ctrl_pipe;
  logic [N_STAGES:0][REG_W-1:0]  rd_pipe;
  logic [N_STAGES:0]             vld_pipe;
  logic [N_STAGES:0]             rdwr_pipe;
  logic [N_STAGES:0]             ld_pipe;

  logic [0:0]    state;
  logic [CW-1:0] cnt;
  logic          hazard, stalling, bubble, adv;
  logic          unused_ld;

  // Load-use: ID reads the register a valid load in EX is about to write.
  assign hazard = (state == RUN) && id_valid && vld_pipe[1] && ld_pipe[1] &&
                  rdwr_pipe[1] &&
                  ((id_use_rs1 && (id_rs1 == rd_pipe[1])) ||
                   (id_use_rs2 && (id_rs2 == rd_pipe[1])));
  assign stalling = (state == STALL) || hazard;

  // flush > stall_ext > hazard
  assign adv          = flush | ~stall_ext;
  assign bubble       = flush | stalling;
  assign pc_le        = flush | (~stall_ext & ~stalling);
  assign ifid_le      = pc_le;
  assign hazard_stall = ~flush & ~stall_ext & stalling;

  assign ctrl_pipe[0] = bubble ? '0 : id_ctrl;
  assign rd_pipe[0]   = bubble ? '0 : id_rd;
  assign vld_pipe[0]  = ~bubble & id_valid;
  assign rdwr_pipe[0] = ~bubble & id_rd_wr;
  assign ld_pipe[0]   = ~bubble & id_is_load;

  for (genvar k = 0; k < N_STAGES; k++) begin : g_stage
    ctrl_pipe_stage #(
      .CTRL_W (CTRL_W),
      .REG_W  (REG_W),
      .MASK   (KEEP_MASK[k*CTRL_W +: CTRL_W])
    ) u_stage (
      .clk    (clk),
      .reset  (reset),
      .en     (adv),
      .d_ctrl (ctrl_pipe[k]),
      .d_vld  (vld_pipe[k]),
      .d_rd   (rd_pipe[k]),
      .d_rdwr (rdwr_pipe[k]),
      .d_ld   (ld_pipe[k]),
      .q_ctrl (ctrl_pipe[k+1]),
      .q_vld  (vld_pipe[k+1]),
      .q_rd   (rd_pipe[k+1]),
      .q_rdwr (rdwr_pipe[k+1]),
      .q_ld   (ld_pipe[k+1])
    );
  end

  assign stage_ctrl  = ctrl_pipe[N_STAGES:1];
  assign stage_rd    = rd_pipe[N_STAGES:1];
  assign stage_valid = vld_pipe[N_STAGES:1];
  assign stage_rd_wr = rdwr_pipe[N_STAGES:1];
  // The last stage's is_load has no consumer.
  assign unused_ld   = ld_pipe[N_STAGES];

  // RUN/STALL sequencing: a hazard starts LOAD_LAT bubbles, flush aborts them
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      cnt   <= '0;
    end else if (flush) begin
      state <= RUN;
      cnt   <= '0;
    end else if (!stall_ext) begin
      if (state == RUN) begin
        if (hazard && (LOAD_LAT > 1)) begin
          state <= STALL;
          cnt   <= CW'(LOAD_LAT - 1);
        end
      end else begin
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) state <= RUN;
      end
    end
  end

`ifdef CTRL_PIPE_STATS_EN
  // Saturating event counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bubble_cnt <= '0;
      flush_cnt  <= '0;
      freeze_cnt <= '0;
    end else begin
      if (hazard_stall && bubble_cnt != 16'hFFFF) bubble_cnt <= bubble_cnt + 16'd1;
      if (flush && flush_cnt != 16'hFFFF)         flush_cnt  <= flush_cnt + 16'd1;
      if (!flush && stall_ext && freeze_cnt != 16'hFFFF)
        freeze_cnt <= freeze_cnt + 16'd1;
    end
  end
`endif

endmodule
